// File: rtl/alu_seq_muldiv.sv
// Sequential execute unit: base integer ops finish in one registered cycle, RV32M mul/div iterate.
// Optional macro ALU_DIV_EARLY_EN resolves divide-by-zero and signed overflow at the START edge.
module alu_seq_muldiv #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [4:0]       SELECT,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic [WIDTH-1:0] RESULT,
   output logic             BUSY,
   output logic             DONE
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [1:0]         op_q, op_d;
   logic               neg_q, neg_d;

   // ---------------------------------------------------------------------------------------------
   // Decode and operand conditioning
   // ---------------------------------------------------------------------------------------------
   logic             is_mul, is_div;
   logic             a_sgn, b_sgn, a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             start_neg;

   assign is_mul = (SELECT[4:3] == 2'b10) && !SELECT[2];
   assign is_div = (SELECT[4:3] == 2'b10) &&  SELECT[2];

   always_comb begin
      if (is_mul) begin
         a_sgn = (SELECT[1:0] == 2'b01) || (SELECT[1:0] == 2'b10);
         b_sgn = (SELECT[1:0] == 2'b01);
      end else begin
         a_sgn = !SELECT[0];
         b_sgn = !SELECT[0];
      end
      a_neg = a_sgn && DATA1[WIDTH-1];
      b_neg = b_sgn && DATA2[WIDTH-1];
      mag_a = a_neg ? -DATA1 : DATA1;
      mag_b = b_neg ? -DATA2 : DATA2;
      // Quotient of a divide-by-zero is all ones regardless of dividend sign.
      if (is_mul) begin
         start_neg = a_neg ^ b_neg;
      end else if (SELECT[1]) begin
         start_neg = a_neg;
      end else begin
         start_neg = (a_neg ^ b_neg) && (DATA2 != '0);
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Single-cycle base operations
   // ---------------------------------------------------------------------------------------------
   logic [SHAMT_W-1:0]      shamt;
   logic signed [WIDTH-1:0] sra_res;
   logic [WIDTH-1:0]        base_res;

   assign shamt   = DATA2[SHAMT_W-1:0];
   assign sra_res = $signed(DATA1) >>> shamt;

   always_comb begin
      base_res = '0;
      case (SELECT)
         5'b00000: base_res = DATA1 + DATA2;
         5'b00001: base_res = DATA1 - DATA2;
         5'b00010: base_res = DATA1 << shamt;
         5'b00011: base_res = {{(WIDTH-1){1'b0}}, ($signed(DATA1) < $signed(DATA2))};
         5'b00100: base_res = {{(WIDTH-1){1'b0}}, (DATA1 < DATA2)};
         5'b00101: base_res = DATA1 ^ DATA2;
         5'b00110: base_res = DATA1 >> shamt;
         5'b00111: base_res = sra_res;
         5'b01000: base_res = DATA1 | DATA2;
         5'b01001: base_res = DATA1 & DATA2;
         5'b01010: base_res = DATA2;
         default:  base_res = '0;
      endcase
   end

   // ---------------------------------------------------------------------------------------------
   // Division shortcut for divide-by-zero and signed overflow
   // ---------------------------------------------------------------------------------------------
   logic             div_early;
   logic [WIDTH-1:0] early_res;

`ifdef ALU_DIV_EARLY_EN
   logic div_zero, div_ovf;

   assign div_zero  = (DATA2 == '0);
   assign div_ovf   = !SELECT[0] && (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA2 == '1);
   assign div_early = is_div && (div_zero || div_ovf);

   always_comb begin
      if (div_zero) begin
         early_res = SELECT[1] ? DATA1 : '1;
      end else begin
         early_res = SELECT[1] ? '0 : DATA1;
      end
   end
`else
   assign div_early = 1'b0;
   assign early_res = '0;
`endif

   // ---------------------------------------------------------------------------------------------
   // Iteration datapath: acc holds {hi, lo}; mul shifts the product in from the top, div shifts
   // dividend bits out of lo into the partial remainder in hi while quotient bits fill lo.
   // ---------------------------------------------------------------------------------------------
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift, div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] step_acc;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   div_pick;
   logic [WIDTH-1:0]   fin_res;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      if (div_ge) begin
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end

      step_acc = (state_q == StMul) ? mul_next : div_next;

      prod     = neg_q ? -step_acc : step_acc;
      div_pick = op_q[1] ? step_acc[2*WIDTH-1:WIDTH] : step_acc[WIDTH-1:0];
      if (state_q == StMul) begin
         fin_res = (op_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      end else begin
         fin_res = neg_q ? -div_pick : div_pick;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      neg_d    = neg_q;

      case (state_q)
         StMul, StDiv: begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d  = StFin;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               result_d = fin_res;
               cnt_d    = '0;
            end
         end
         default: begin
            // StFin is the DONE cycle and accepts a new START just like StIdle.
            state_d = StIdle;
            busy_d  = 1'b0;
            if (START) begin
               if (is_mul) begin
                  state_d = StMul;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  acc_d   = {{WIDTH{1'b0}}, mag_b};
                  opnd_d  = mag_a;
                  op_d    = SELECT[1:0];
                  neg_d   = start_neg;
               end else if (div_early) begin
                  result_d = early_res;
                  done_d   = 1'b1;
               end else if (is_div) begin
                  state_d = StDiv;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  acc_d   = {{WIDTH{1'b0}}, mag_a};
                  opnd_d  = mag_b;
                  op_d    = SELECT[1:0];
                  neg_d   = start_neg;
               end else begin
                  result_d = base_res;
                  done_d   = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= StIdle;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
      end
   end

   assign RESULT = result_q;
   assign BUSY   = busy_q;
   assign DONE   = done_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Bench for alu_seq_muldiv: directed vector table, hand-written handshake/reset sequences and
// random operations checked against a plain-arithmetic reference model.
module tb_alu_seq_muldiv;

   localparam logic [4:0] OpAdd  = 5'd0,  OpSub  = 5'd1,  OpSll  = 5'd2,  OpSlt  = 5'd3;
   localparam logic [4:0] OpSltu = 5'd4,  OpXor  = 5'd5,  OpSrl  = 5'd6,  OpSra  = 5'd7;
   localparam logic [4:0] OpOr   = 5'd8,  OpAnd  = 5'd9,  OpFwd  = 5'd10;
   localparam logic [4:0] OpMul  = 5'd16, OpMulh = 5'd17, OpMulhsu = 5'd18, OpMulhu = 5'd19;
   localparam logic [4:0] OpDiv  = 5'd20, OpDivu = 5'd21, OpRem  = 5'd22, OpRemu = 5'd23;

`ifdef ALU_DIV_EARLY_EN
   localparam bit Early = 1'b1;
`else
   localparam bit Early = 1'b0;
`endif
   localparam int CornerLat = Early ? 1 : 33;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        START;
   logic [4:0]  SELECT;
   logic [31:0] DATA1, DATA2;
   logic [31:0] RESULT;
   logic        BUSY, DONE;

   int total = 0;
   int bad   = 0;

   alu_seq_muldiv #(.WIDTH(32)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .START (START),
      .SELECT(SELECT),
      .DATA1 (DATA1),
      .DATA2 (DATA2),
      .RESULT(RESULT),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [4:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] e, input int l);
      vec_t v;
      v.sel = s; v.a = a; v.b = b; v.exp = e; v.lat = l;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
      end
   endtask

   // Reference model: RISC-V semantics in 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [4:0] s, input logic [31:0] a,
                                         input logic [31:0] b);
      longint             sa, sb, ubs;
      logic [63:0]        ua, ub, p;
      logic signed [31:0] as32;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      ua   = {32'h0, a};
      ub   = {32'h0, b};
      ubs  = longint'(ub);
      as32 = a;
      case (s)
         OpAdd:    return a + b;
         OpSub:    return a - b;
         OpSll:    return a << b[4:0];
         OpSlt:    return (sa < sb) ? 32'd1 : 32'd0;
         OpSltu:   return (a < b) ? 32'd1 : 32'd0;
         OpXor:    return a ^ b;
         OpSrl:    return a >> b[4:0];
         OpSra:    return as32 >>> b[4:0];
         OpOr:     return a | b;
         OpAnd:    return a & b;
         OpFwd:    return b;
         OpMul:    begin p = ua * ub;  return p[31:0];  end
         OpMulh:   begin p = sa * sb;  return p[63:32]; end
         OpMulhsu: begin p = sa * ubs; return p[63:32]; end
         OpMulhu:  begin p = ua * ub;  return p[63:32]; end
         OpDiv:    begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            p = sa / sb;
            return p[31:0];
         end
         OpDivu:   return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         OpRem:    begin
            if (b == 32'h0) return a;
            p = sa % sb;
            return p[31:0];
         end
         OpRemu:   return (b == 32'h0) ? a : a % b;
         default:  return 32'h0;
      endcase
   endfunction

   function automatic int exp_lat(input logic [4:0] s, input logic [31:0] a,
                                  input logic [31:0] b);
      if (s[4:3] != 2'b10) return 1;
      if (Early && s[2] && (b == 32'h0 ||
          (!s[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
      return 33;
   endfunction

   // Issue one op starting at a negedge; returns at the negedge where DONE is seen (or timeout).
   // poke > 0 re-pulses START with a different op in that cycle while the first is running.
   task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input int poke, output logic [31:0] res, output int lat,
                         output logic busy1, output logic ovl);
      START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
      @(posedge CLK);
      #1;
      START  = 1'b0;
      SELECT = 5'($urandom);
      DATA1  = $urandom;
      DATA2  = $urandom;
      lat = 0; busy1 = 1'b0; ovl = 1'b0; res = 32'hx;
      for (int c = 1; c <= 100; c++) begin
         @(negedge CLK);
         if (c == 1) busy1 = BUSY;
         if (BUSY && DONE) ovl = 1'b1;
         if (DONE) begin
            lat = c;
            res = RESULT;
            break;
         end
         if (poke > 0 && c == poke) begin
            START = 1'b1; SELECT = OpAdd; DATA1 = 32'd1; DATA2 = 32'd1;
         end else if (poke > 0 && c == poke + 1) begin
            START = 1'b0;
         end
      end
      START = 1'b0;
   endtask

   task automatic check_op(input string name, input int idx, input logic [4:0] sel,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                           input int lat_exp);
      logic [31:0] res;
      int          lat;
      logic        busy1, ovl;
      run_op(sel, a, b, 0, res, lat, busy1, ovl);
      chk({name, "_result"}, idx, res, exp);
      chk({name, "_latency"}, idx, 32'(lat), 32'(lat_exp));
      chk({name, "_busy_c1"}, idx, {31'h0, busy1}, {31'h0, (lat_exp > 1)});
      chk({name, "_busy_done"}, idx, {31'h0, ovl}, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] res, a, b;
      logic [4:0]  sel;
      logic        busy1, ovl;
      int          lat, dones, r;

      add(OpAdd,  32'd5,          32'd10,         32'd15,         1);
      add(OpSub,  32'd15,         32'd10,         32'd5,          1);
      add(OpSra,  32'h8000_0000,  32'd4,          32'hF800_0000,  1);
      add(OpSltu, 32'd1,          32'hFFFF_FFFF,  32'd1,          1);
      add(OpSlt,  32'd1,          32'hFFFF_FFFF,  32'd0,          1);
      add(OpSll,  32'd1,          32'd31,         32'h8000_0000,  1);
      add(OpSll,  32'd3,          32'd33,         32'd6,          1);
      add(OpSrl,  32'h8000_0000,  32'd4,          32'h0800_0000,  1);
      add(OpXor,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1);
      add(OpOr,   32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1);
      add(OpAnd,  32'h0000_00F0,  32'h0000_003C,  32'h0000_0030,  1);
      add(OpFwd,  32'd1,          32'hDEAD_BEEF,  32'hDEAD_BEEF,  1);
      add(5'd11,  32'd7,          32'd9,          32'd0,          1);
      add(OpAdd,  32'd1,          32'd1,          32'd2,          1);
      add(5'd31,  32'd7,          32'd9,          32'd0,          1);
      add(OpMul,  32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB,  33);
      add(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  33);
      add(OpMulh, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          33);
      add(OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  33);
      add(OpMulh, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33);
      add(OpMul,  32'h1234_5678,  32'h10,         32'h2345_6780,  33);
      add(OpDiv,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
      add(OpRem,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
      add(OpDiv,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33);
      add(OpRem,  32'd7,          32'hFFFF_FFFE,  32'd1,          33);
      add(OpDivu, 32'd7,          32'd0,          32'hFFFF_FFFF,  CornerLat);
      add(OpRemu, 32'd7,          32'd0,          32'd7,          CornerLat);
      add(OpDiv,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  CornerLat);
      add(OpRem,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  CornerLat);
      add(OpDiv,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  CornerLat);
      add(OpRem,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          CornerLat);
      add(OpDivu, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33);
      add(OpRemu, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33);
      add(OpDivu, 32'd100,        32'd7,          32'd14,         33);
      add(OpRemu, 32'd100,        32'd7,          32'd2,          33);
      add(OpDiv,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33);
      add(OpRem,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33);

      RESET = 1'b1; START = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_result", 0, RESULT, 32'h0);
      chk("reset_busy",   0, {31'h0, BUSY}, 32'h0);
      chk("reset_done",   0, {31'h0, DONE}, 32'h0);
      RESET = 1'b0;

      // Consecutive ops start in the DONE cycle of the previous one (back-to-back).
      foreach (vecs[i]) check_op("vec", i, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp,
                                 vecs[i].lat);

      // START while busy must be ignored and must not disturb the running divide.
      run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 10, res, lat, busy1, ovl);
      chk("poke_result",  0, res, 32'hFFFF_FFFD);
      chk("poke_latency", 0, 32'(lat), 32'd33);
      dones = 0;
      repeat (3) begin
         @(negedge CLK);
         if (DONE) dones++;
      end
      chk("poke_extra_done", 0, 32'(dones), 32'd0);
      chk("poke_hold",       0, RESULT, 32'hFFFF_FFFD);

      // Reset in the middle of a multiply aborts it with no DONE.
      START = 1'b1; SELECT = OpMul; DATA1 = 32'd6; DATA2 = 32'd7;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (5) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      chk("midreset_result", 0, RESULT, 32'h0);
      chk("midreset_busy",   0, {31'h0, BUSY}, 32'h0);
      dones = 0;
      repeat (40) begin
         @(negedge CLK);
         if (DONE || BUSY) dones++;
      end
      chk("midreset_no_done", 0, 32'(dones), 32'd0);
      check_op("post_reset", 0, OpAdd, 32'd2, 32'd3, 32'd5, 1);

      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      sel = 5'(16 + $urandom_range(0, 7));
         else if (r < 8) sel = 5'($urandom_range(0, 10));
         else            sel = 5'($urandom_range(0, 31));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = 32'($urandom_range(0, 20)); b = 32'($urandom_range(0, 20)); end
            default: ;
         endcase
         check_op("rand", i, sel, a, b, model(sel, a, b), exp_lat(sel, a, b));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
